// File: rtl/tokens_pkg.sv
// ============================================================================
// Module      : tokens_pkg
// Description : Shared state encoding, parameter defaults and helpers for the
//               token injector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tokens_pkg;

  localparam int c_sync_stages_default = 2;
  localparam int c_to_w_default        = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_REQ   = 3'd2,
    ST_REL   = 3'd3,
    ST_FIN   = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  // Execute bit for token number idx; the pattern repeats every eight tokens.
  function automatic logic exb_bit(input logic [7:0] pat, input logic [2:0] idx);
    return pat[idx];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ack_sync.sv
// ============================================================================
// Module      : ack_sync
// Description : Multi-flop synchroniser for the asynchronous ACKIN input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ack_sync #(
  parameter int SYNC_STAGES = tokens_pkg::c_sync_stages_default
) (
  input  logic clk,
  input  logic resetn,
  input  logic ackin,
  output logic ack_synced
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ackin};
    end
  end

  assign ack_synced = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/token_injector.sv
// ============================================================================
// Module      : token_injector
// Description : Issues a burst of four-phase request/acknowledge handshakes
//               to a downstream ring, with per-token execute bit and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module token_injector #(
  parameter int SYNC_STAGES = tokens_pkg::c_sync_stages_default,
  parameter int TO_W        = tokens_pkg::c_to_w_default
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] ntokens,
  input  logic [7:0] exbpat,
  output logic       sendout,
  output logic       exbout,
  input  logic       ackin,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] tokcnt
);

  import tokens_pkg::*;

  localparam logic [TO_W-1:0] c_to_max  = '1;
  localparam logic [TO_W-1:0] c_to_one  = TO_W'(1);
  localparam logic [TO_W-1:0] c_to_last = c_to_max - c_to_one;

  state_t          r_state;
  logic            r_sendout;
  logic            r_exbout;
  logic            r_done;
  logic            r_err;
  logic [7:0]      r_tokcnt;
  logic [7:0]      r_ntok;
  logic [7:0]      r_pat;
  logic [TO_W-1:0] r_to;

  logic            w_ack;
  logic [7:0]      w_tokcnt_inc;

  ack_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk        (clk),
    .resetn     (resetn),
    .ackin      (ackin),
    .ack_synced (w_ack)
  );

  assign w_tokcnt_inc = r_tokcnt + 8'd1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_sendout <= 1'b0;
      r_exbout  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_tokcnt  <= 8'd0;
      r_ntok    <= 8'd0;
      r_pat     <= 8'd0;
      r_to      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_tokcnt <= 8'd0;
            r_ntok   <= ntokens;
            r_pat    <= exbpat;
            if (ntokens == 8'd0) begin
              r_state <= ST_FIN;
            end else begin
              // Execute bit is loaded on entry so it is valid for the whole SETUP cycle.
              r_exbout <= exb_bit(exbpat, 3'd0);
              r_state  <= ST_SETUP;
            end
          end
        end

        ST_SETUP: begin
          r_sendout <= 1'b1;
          r_to      <= '0;
          r_state   <= ST_REQ;
        end

        ST_REQ: begin
          if (w_ack) begin
            r_sendout <= 1'b0;
            r_to      <= '0;
            r_state   <= ST_REL;
          end else if (r_to == c_to_last) begin
            r_sendout <= 1'b0;
            r_err     <= 1'b1;
            r_to      <= c_to_max;
            r_state   <= ST_ERROR;
          end else begin
            r_to <= r_to + c_to_one;
          end
        end

        ST_REL: begin
          if (!w_ack) begin
            r_tokcnt <= w_tokcnt_inc;
            if (w_tokcnt_inc == r_ntok) begin
              r_state <= ST_FIN;
            end else begin
              r_exbout <= exb_bit(r_pat, w_tokcnt_inc[2:0]);
              r_state  <= ST_SETUP;
            end
          end else if (r_to == c_to_last) begin
            r_err   <= 1'b1;
            r_to    <= c_to_max;
            r_state <= ST_ERROR;
          end else begin
            r_to <= r_to + c_to_one;
          end
        end

        ST_FIN: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end

        ST_ERROR: begin
          r_sendout <= 1'b0;
          r_err     <= 1'b1;
        end

        default: begin
          r_sendout <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign sendout = r_sendout;
  assign exbout  = r_exbout;
  assign done    = r_done;
  assign err     = r_err;
  assign tokcnt  = r_tokcnt;
  assign busy    = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_token_injector.sv
// ============================================================================
// Module      : tb_token_injector
// Description : Directed and randomized bench for token_injector with a
//               responsive downstream acknowledge model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_token_injector;

  localparam int SYNC = 2;
  localparam int TOW  = 4;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [7:0] ntokens;
  logic [7:0] exbpat;
  logic       sendout;
  logic       exbout;
  logic       ackin;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] tokcnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // downstream model control
  bit ack_en    = 1'b0;
  int ack_delay = 4;
  int ack_rise_cyc = 0;

  // observation state
  logic exb_q[$];
  int   fall_lat_q[$];
  int   first_rise_cyc = 0;
  int   setup_viol = 0;
  int   exb_viol   = 0;
  int   send_hi_cnt = 0;
  int   done_cnt   = 0;
  logic prev_send  = 1'b0;
  logic prev_exb   = 1'b0;
  logic hs_exb     = 1'b0;
  bit   hs_active  = 1'b0;

  token_injector #(
    .SYNC_STAGES (SYNC),
    .TO_W        (TOW)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .ntokens (ntokens),
    .exbpat  (exbpat),
    .sendout (sendout),
    .exbout  (exbout),
    .ackin   (ackin),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .tokcnt  (tokcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream ring: ACKIN follows SENDOUT after ack_delay cycles.
  initial begin
    int cnt;
    cnt = 0;
    ackin = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        ackin = 1'b0;
        cnt = 0;
      end else if (ack_en) begin
        if (sendout !== ackin) begin
          cnt++;
          if (cnt >= ack_delay) begin
            if (sendout === 1'b1) ack_rise_cyc = cyc;
            ackin = sendout;
            cnt = 0;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  // Passive monitor of handshakes, execute bits and pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        hs_active = 1'b0;
      end else begin
        if (sendout === 1'b1 && prev_send !== 1'b1) begin
          if (exb_q.size() == 0) first_rise_cyc = cyc;
          if (exbout !== prev_exb) setup_viol++;
          exb_q.push_back(exbout);
          hs_exb = exbout;
          hs_active = 1'b1;
        end else if (hs_active && exbout !== hs_exb) begin
          exb_viol++;
        end
        if (sendout === 1'b0 && prev_send === 1'b1) fall_lat_q.push_back(cyc - ack_rise_cyc);
        if (hs_active && sendout === 1'b0 && ackin === 1'b0) hs_active = 1'b0;
      end
      if (sendout === 1'b1) send_hi_cnt++;
      if (done === 1'b1) done_cnt++;
      prev_send = sendout;
      prev_exb  = exbout;
    end
  end

  task automatic clear_obs();
    exb_q.delete();
    fall_lat_q.delete();
    setup_viol  = 0;
    exb_viol    = 0;
    send_hi_cnt = 0;
    done_cnt    = 0;
  endtask

  task automatic pulse_start(input int n, input logic [7:0] pat);
    start   = 1'b1;
    ntokens = 8'(n);
    exbpat  = pat;
    @(negedge clk);
    start   = 1'b0;
    ntokens = 8'($urandom);
    exbpat  = 8'($urandom);
  endtask

  // One burst against the model: bit i of the pattern for token i mod 8.
  task automatic run_burst(input string tag, input int n, input logic [7:0] pat,
                           input int dly, input bit extra);
    int   start_cyc;
    int   done_cyc;
    int   budget;
    int   bad_lat;
    bit   got_done;
    logic [31:0] exp_v;
    logic [31:0] obs_v;
    logic [7:0]  pv;
    clear_obs();
    ack_en    = 1'b1;
    ack_delay = dly;
    got_done  = 1'b0;
    done_cyc  = 0;
    start_cyc = cyc;
    pulse_start(n, pat);
    if (extra) begin
      for (int i = 0; i < 200; i++) begin
        if (exb_q.size() >= 2) break;
        @(negedge clk);
      end
      check({tag, "_second_token_seen"}, 32'(exb_q.size() >= 2), 32'd1);
      pulse_start(7, 8'hFF);
    end
    budget = 40 * (n + 1) + 20;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        got_done = 1'b1;
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    repeat (3) @(negedge clk);

    pv = pat;
    exp_v = '0;
    obs_v = '0;
    for (int i = 0; i < n && i < 32; i++) exp_v[i] = pv[i % 8];
    for (int i = 0; i < exb_q.size() && i < 32; i++) obs_v[i] = exb_q[i];
    bad_lat = 0;
    foreach (fall_lat_q[i]) if (fall_lat_q[i] != SYNC + 1) bad_lat++;

    check({tag, "_handshakes"}, 32'(exb_q.size()), 32'(n));
    check({tag, "_exb_seq"}, obs_v, exp_v);
    check({tag, "_tokcnt"}, 32'(tokcnt), 32'(n));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_exb_stable"}, 32'(exb_viol + setup_viol), 32'd0);
    if (n == 0) begin
      check({tag, "_done_latency"}, 32'(done_cyc - start_cyc), 32'd2);
      check({tag, "_sendout_cycles"}, 32'(send_hi_cnt), 32'd0);
    end else begin
      check({tag, "_start_latency"}, 32'(first_rise_cyc - start_cyc), 32'd2);
      check({tag, "_ack_latency"}, 32'(bad_lat), 32'd0);
    end
  endtask

  initial begin
    bit seen;
    resetn  = 1'b0;
    start   = 1'b0;
    ntokens = 8'd0;
    exbpat  = 8'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_sendout", 32'(sendout), 32'd0);
    check("rst_exbout",  32'(exbout),  32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_tokcnt",  32'(tokcnt),  32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Spurious acknowledge while idle
    ackin = 1'b1;
    repeat (6) @(negedge clk);
    check("spurious_busy", 32'(busy), 32'd0);
    check("spurious_sendout", 32'(sendout), 32'd0);
    ackin = 1'b0;
    repeat (4) @(negedge clk);

    run_burst("three",  3,  8'b0000_0101, 4, 1'b0);
    run_burst("zero",   0,  8'hFF,        4, 1'b0);
    run_burst("ten",    10, 8'hA5,        3, 1'b0);
    run_burst("restart", 4, 8'($urandom), 2, 1'b1);
    for (int r = 0; r < 4; r++) begin
      run_burst($sformatf("rand%0d", r), int'($urandom_range(1, 12)),
                8'($urandom), int'($urandom_range(1, 5)), 1'b0);
    end

    // Reset asserted mid-handshake
    clear_obs();
    ack_en = 1'b1;
    ack_delay = 3;
    pulse_start(5, 8'h3C);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exb_q.size() >= 2 && sendout === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("midrst_in_req", 32'(seen), 32'd1);
    check("midrst_tokcnt_before", 32'(tokcnt), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_sendout", 32'(sendout), 32'd0);
    check("midrst_busy",    32'(busy),    32'd0);
    check("midrst_tokcnt",  32'(tokcnt),  32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    run_burst("after_rst", 6, 8'($urandom), 2, 1'b0);

    // Unresponsive ring: handshake timeout
    clear_obs();
    ack_en = 1'b0;
    pulse_start(2, 8'h01);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (err === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    check("to_err_seen", 32'(seen), 32'd1);
    check("to_sendout",  32'(sendout), 32'd0);
    check("to_req_cycles", 32'(send_hi_cnt), 32'((1 << TOW) - 1));
    check("to_busy", 32'(busy), 32'd1);
    repeat (20) @(negedge clk);
    pulse_start(3, 8'hFF);
    repeat (5) @(negedge clk);
    check("to_err_sticky", 32'(err), 32'd1);
    check("to_no_resend", 32'(send_hi_cnt), 32'((1 << TOW) - 1));
    resetn = 1'b0;
    @(negedge clk);
    check("to_rst_err",  32'(err),  32'd0);
    check("to_rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
